ex_hazard_mem_latch: RTL and testbench
======================================

// Module: ex_hazard_mem_latch
// PURPOSE
//   Execute-stage datapath of the 5-stage PA-RISC-subset pipeline, merged with the data-hazard
//   detection/forwarding unit and the EX/MEM pipeline register. Consumes ID/EX register outputs,
//   computes ALU result, branch decision and operand-forward selects, and latches EX results
//   for the MEM stage.
// PARAMETERS
//   (none)   fixed widths: 32-bit data, 8-bit instruction addresses, 5-bit register ids
// PORTS
//   CLK             in   1   rising-edge clock
//   RST             in   1   asynchronous, active-high reset
//   RET_ADDR        in   8   return (link) address from ID/EX
//   TA_IN           in   8   branch target address from ID/EX
//   FPA             in   32  operand A (already forwarded)
//   FPB             in   32  operand B / store data (already forwarded)
//   IM              in   21  raw immediate field
//   IDR             in   5   destination register of the EX instruction
//   CTRL            in   21  {PSW_LE_RE[20:19],B,SOH_OP[17:15],ALU_OP[14:11],RAM_CTRL[10:7],L,RF_LE,UB,NEG_COND,COND[2:0]}
//   RA, RB          in   5   source registers of the instruction in ID
//   SR              in   2   source usage of the ID instruction: [1]=RA used, [0]=RB used
//   WB_RD           in   5   destination register in WB
//   WB_RF_LE        in   1   WB register-file write enable
//   EX_J            out  1   take branch (flush IF/ID, redirect PC)
//   TARGET_ADDRESS  out  8   = TA_IN
//   EX_OUT          out  32  combinational EX result (forward source 01)
//   EX_OUT_IN       out  32  registered EX_OUT (MEM address / ALU result)
//   EX_DI_IN        out  32  registered store data (FPB)
//   EX_RD_IN        out  5   registered IDR (the MEM-stage rd)
//   L_IN            out  1   registered load select
//   RF_LE_IN        out  1   registered RF_LE (the MEM-stage write enable)
//   RAM_CTRL_IN     out  4   registered RAM control
//   NOP             out  1   insert bubble into ID/EX control
//   LE              out  1   PC and IF/ID load enable (0 = stall)
//   A_S, B_S        out  2   operand-A/B forward select
// BEHAVIOUR
// - Operand handler (SOH_OP) gives op B:
//   - 000 FPB; 001 sext(IM[10:0]); 010 sext(IM[13:0]); 011 {IM[20:0],11'b0}; 100 zext(IM[4:0]).
//   - Other codes give FPB.
// - ALU on (FPA, opB):
//   - 0000 A+B; 0001 A+B+C; 0010 A-B; 0011 A-B-~C; 0100 B-A; 0101 A|B; 0110 A^B; 0111 A&B.
//   - 1000 A; 1001 B; others 0.
// - Flags:
//   - Z = result==0; N = result[31].
//   - C = carry-out; for subtracts C=1 means no borrow.
//   - V = signed overflow of add/sub, 0 for logic ops.
// - Carry input C is the PSW carry flop, used only when PSW_LE_RE[0]=1, else 0.
//   - The flop loads the ALU C on CLK when PSW_LE_RE[1]=1.
//   - It resets to 0.
// - EX_OUT = UB ? {24'b0,RET_ADDR} : ALU result.
// - Condition COND:
//   - 000 never; 001 Z; 010 N^V; 011 (N^V)|Z; 100 ~C; 101 ~C|Z; 110 V; 111 result[0].
//   - The result is XORed with NEG_COND.
// - EX_J = UB | (B & cond). Combinational, same cycle.
// - Pass-throughs to the EX/MEM register: EX_DI=FPB, EX_RD=IDR, L, RF_LE, RAM_CTRL.
// - EX/MEM register:
//   - Loads every rising CLK; there is no enable or flush.
//   - RST clears all registered outputs and the PSW carry to 0 immediately (async).
// - Forwarding, per A (RA) and B (RB), first match wins:
//   - EX (IDR, RF_LE) -> 01.
//   - MEM (EX_RD_IN, RF_LE_IN) -> 10.
//   - WB (WB_RD, WB_RF_LE) -> 11.
//   - Otherwise 00 (register file).
//   - A match needs write enable=1, equal ids and id != 0; GR0 is never forwarded.
// - Load-use stall:
//   - Condition: L=1 & RF_LE=1 & IDR!=0 & ((SR[1] & RA==IDR) | (SR[0] & RB==IDR)).
//   - When true: NOP=1, LE=0.
//   - Otherwise NOP=0, LE=1.
//   - The stall lasts one cycle; the next cycle forwards from MEM (10).
// - All outputs other than the EX/MEM register outputs are purely combinational.
// TESTING
// - ADD: FPA=5, FPB=7, ALU=0000, SOH=000, RF_LE=1, IDR=3 -> EX_OUT=12; after CLK EX_OUT_IN=12, EX_RD_IN=3, RF_LE_IN=1.
// - Reset: RST high mid-cycle -> EX_OUT_IN, EX_DI_IN, EX_RD_IN, L_IN, RF_LE_IN, RAM_CTRL_IN and PSW C all 0 without a CLK edge.
// - Forwarding, RA=3 and SR=10:
//   - EX IDR=3, RF_LE=1 -> A_S=01.
//   - Only WB_RD=3 -> A_S=11.
//   - RA=0 -> A_S=00.
// - Load-use: L=1, RF_LE=1, IDR=4, RB=4, SR=01 -> NOP=1, LE=0; with SR=00 -> NOP=0, LE=1.
// - Branch, FPA=FPB=9, ALU=0010, B=1, COND=001:
//   - NEG_COND=0 -> EX_J=1, TARGET_ADDRESS=TA_IN.
//   - NEG_COND=1 -> EX_J=0.
//   - UB=1, RET_ADDR=0x2C -> EX_J=1, EX_OUT=0x2C.
// - Carry chain: 0xFFFFFFFF+1 with PSW_LE_RE=10, then ALU=0001 0+0 with PSW_LE_RE=01 -> EX_OUT=1.

Source files
------------

// File: rtl/ex_hazard_mem_latch.sv
// Execute stage of the PA-RISC-subset pipeline: operand handler, ALU, branch condition,
// hazard detection and forwarding selects, PSW carry, and the EX/MEM pipeline register.
module ex_hazard_mem_latch (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ret_addr_i,
  input  logic [7:0]  ta_in_i,
  input  logic [31:0] fpa_i,
  input  logic [31:0] fpb_i,
  input  logic [20:0] im_i,
  input  logic [4:0]  idr_i,
  input  logic [20:0] ctrl_i,
  input  logic [4:0]  ra_i,
  input  logic [4:0]  rb_i,
  input  logic [1:0]  sr_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        wb_rf_le_i,
  output logic        ex_j_o,
  output logic [7:0]  target_address_o,
  output logic [31:0] ex_out_o,
  output logic [31:0] ex_out_in_o,
  output logic [31:0] ex_di_in_o,
  output logic [4:0]  ex_rd_in_o,
  output logic        l_in_o,
  output logic        rf_le_in_o,
  output logic [3:0]  ram_ctrl_in_o,
  output logic        nop_o,
  output logic        le_o,
  output logic [1:0]  a_s_o,
  output logic [1:0]  b_s_o
);

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_ADC   = 4'b0001;
  localparam logic [3:0] ALU_SUB   = 4'b0010;
  localparam logic [3:0] ALU_SBC   = 4'b0011;
  localparam logic [3:0] ALU_RSB   = 4'b0100;
  localparam logic [3:0] ALU_OR    = 4'b0101;
  localparam logic [3:0] ALU_XOR   = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_PASSA = 4'b1000;
  localparam logic [3:0] ALU_PASSB = 4'b1001;

  logic [1:0] psw_le_re;
  logic       br_en;
  logic [2:0] soh_op;
  logic [3:0] alu_op;
  logic [3:0] ram_ctrl;
  logic       load_sel;
  logic       rf_le;
  logic       ub;
  logic       neg_cond;
  logic [2:0] cond;

  assign {psw_le_re, br_en, soh_op, alu_op, ram_ctrl, load_sel, rf_le, ub, neg_cond, cond} = ctrl_i;

  logic [31:0] ex_out_in_q, ex_di_in_q;
  logic [4:0]  ex_rd_in_q;
  logic        l_in_q, rf_le_in_q;
  logic [3:0]  ram_ctrl_in_q;
  logic        c_q, c_d;

  logic [31:0] op_b;
  logic [32:0] sum;
  logic [31:0] alu_res;
  logic        alu_c, alu_v, alu_z, alu_n;
  logic        cin;
  logic        cond_raw;

  // NOTE: every signal written in an always_comb gets a default first, so no path
  // through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    op_b = fpb_i;
    case (soh_op)
      3'b001:  op_b = {{21{im_i[10]}}, im_i[10:0]};
      3'b010:  op_b = {{18{im_i[13]}}, im_i[13:0]};
      3'b011:  op_b = {im_i, 11'b0};
      3'b100:  op_b = {27'b0, im_i[4:0]};
      default: op_b = fpb_i;
    endcase
  end

  assign cin = psw_le_re[0] & c_q;

  // Subtracts are A + ~B + carry-in, so carry-out = 1 means "no borrow".
  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_op)
      ALU_ADD, ALU_ADC: begin
        sum     = {1'b0, fpa_i} + {1'b0, op_b} + {32'b0, (alu_op == ALU_ADC) & cin};
        alu_res = sum[31:0];
        alu_c   = sum[32];
        alu_v   = (fpa_i[31] == op_b[31]) && (alu_res[31] != fpa_i[31]);
      end
      ALU_SUB, ALU_SBC: begin
        sum     = {1'b0, fpa_i} + {1'b0, ~op_b} + {32'b0, (alu_op == ALU_SUB) | cin};
        alu_res = sum[31:0];
        alu_c   = sum[32];
        alu_v   = (fpa_i[31] != op_b[31]) && (alu_res[31] != fpa_i[31]);
      end
      ALU_RSB: begin
        sum     = {1'b0, op_b} + {1'b0, ~fpa_i} + 33'd1;
        alu_res = sum[31:0];
        alu_c   = sum[32];
        alu_v   = (op_b[31] != fpa_i[31]) && (alu_res[31] != op_b[31]);
      end
      ALU_OR:    alu_res = fpa_i | op_b;
      ALU_XOR:   alu_res = fpa_i ^ op_b;
      ALU_AND:   alu_res = fpa_i & op_b;
      ALU_PASSA: alu_res = fpa_i;
      ALU_PASSB: alu_res = op_b;
      default:   alu_res = '0;
    endcase
  end

  assign alu_z = (alu_res == 32'd0);
  assign alu_n = alu_res[31];

  always_comb begin
    cond_raw = 1'b0;
    case (cond)
      3'd1:    cond_raw = alu_z;
      3'd2:    cond_raw = alu_n ^ alu_v;
      3'd3:    cond_raw = (alu_n ^ alu_v) | alu_z;
      3'd4:    cond_raw = ~alu_c;
      3'd5:    cond_raw = ~alu_c | alu_z;
      3'd6:    cond_raw = alu_v;
      3'd7:    cond_raw = alu_res[0];
      default: cond_raw = 1'b0;
    endcase
  end

  assign ex_j_o           = ub | (br_en & (cond_raw ^ neg_cond));
  assign target_address_o = ta_in_i;
  assign ex_out_o         = ub ? {24'b0, ret_addr_i} : alu_res;

  // Priority EX > MEM > WB; GR0 is hardwired zero and is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic ex_we,  input logic [4:0] ex_rd,
                                         input logic mem_we, input logic [4:0] mem_rd,
                                         input logic wb_we,  input logic [4:0] wb_rd);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != 5'd0) begin
      if (ex_we && ex_rd == rs)        sel = 2'b01;
      else if (mem_we && mem_rd == rs) sel = 2'b10;
      else if (wb_we && wb_rd == rs)   sel = 2'b11;
    end
    return sel;
  endfunction

  assign a_s_o = fwd_sel(ra_i, rf_le, idr_i, rf_le_in_q, ex_rd_in_q, wb_rf_le_i, wb_rd_i);
  assign b_s_o = fwd_sel(rb_i, rf_le, idr_i, rf_le_in_q, ex_rd_in_q, wb_rf_le_i, wb_rd_i);

  assign nop_o = load_sel & rf_le & (idr_i != 5'd0) &
                 ((sr_i[1] & (ra_i == idr_i)) | (sr_i[0] & (rb_i == idr_i)));
  assign le_o  = ~nop_o;

  assign c_d = psw_le_re[1] ? alu_c : c_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_out_in_q   <= '0;
      ex_di_in_q    <= '0;
      ex_rd_in_q    <= '0;
      l_in_q        <= 1'b0;
      rf_le_in_q    <= 1'b0;
      ram_ctrl_in_q <= '0;
      c_q           <= 1'b0;
    end else begin
      ex_out_in_q   <= ex_out_o;
      ex_di_in_q    <= fpb_i;
      ex_rd_in_q    <= idr_i;
      l_in_q        <= load_sel;
      rf_le_in_q    <= rf_le;
      ram_ctrl_in_q <= ram_ctrl;
      c_q           <= c_d;
    end
  end

  assign ex_out_in_o   = ex_out_in_q;
  assign ex_di_in_o    = ex_di_in_q;
  assign ex_rd_in_o    = ex_rd_in_q;
  assign l_in_o        = l_in_q;
  assign rf_le_in_o    = rf_le_in_q;
  assign ram_ctrl_in_o = ram_ctrl_in_q;

endmodule

// File: tb/tb_ex_hazard_mem_latch.sv
// Scoreboard bench for ex_hazard_mem_latch: a driver pushes model-predicted responses,
// a negedge monitor pops and compares them against the DUT.
module tb_ex_hazard_mem_latch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ret_addr_i = '0, ta_in_i = '0;
  logic [31:0] fpa_i = '0, fpb_i = '0;
  logic [20:0] im_i = '0, ctrl_i = '0;
  logic [4:0]  idr_i = '0, ra_i = '0, rb_i = '0, wb_rd_i = '0;
  logic [1:0]  sr_i = '0;
  logic        wb_rf_le_i = 1'b0;
  logic        ex_j_o, l_in_o, rf_le_in_o, nop_o, le_o;
  logic [7:0]  target_address_o;
  logic [31:0] ex_out_o, ex_out_in_o, ex_di_in_o;
  logic [4:0]  ex_rd_in_o;
  logic [3:0]  ram_ctrl_in_o;
  logic [1:0]  a_s_o, b_s_o;

  ex_hazard_mem_latch dut (
    .clk(clk), .rst(rst), .ret_addr_i(ret_addr_i), .ta_in_i(ta_in_i),
    .fpa_i(fpa_i), .fpb_i(fpb_i), .im_i(im_i), .idr_i(idr_i), .ctrl_i(ctrl_i),
    .ra_i(ra_i), .rb_i(rb_i), .sr_i(sr_i), .wb_rd_i(wb_rd_i), .wb_rf_le_i(wb_rf_le_i),
    .ex_j_o(ex_j_o), .target_address_o(target_address_o), .ex_out_o(ex_out_o),
    .ex_out_in_o(ex_out_in_o), .ex_di_in_o(ex_di_in_o), .ex_rd_in_o(ex_rd_in_o),
    .l_in_o(l_in_o), .rf_le_in_o(rf_le_in_o), .ram_ctrl_in_o(ram_ctrl_in_o),
    .nop_o(nop_o), .le_o(le_o), .a_s_o(a_s_o), .b_s_o(b_s_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ret_addr, ta;
    logic [31:0] fpa, fpb;
    logic [20:0] im;
    logic [4:0]  idr, ra, rb, wb_rd;
    logic [1:0]  psw, sr;
    logic [2:0]  soh, cond;
    logic [3:0]  alu, ram;
    logic        b, l, rf_le, ub, neg, wb_rf_le;
  } stim_t;

  typedef struct {
    logic        ex_j, nop, le, l, rf_le;
    logic [7:0]  target;
    logic [31:0] ex_out, out_in, di;
    logic [1:0]  a_s, b_s;
    logic [4:0]  rd;
    logic [3:0]  ram;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference state of the EX/MEM register and the PSW carry.
  logic [31:0] m_out, m_di, n_out, n_di;
  logic [4:0]  m_rd, n_rd;
  logic        m_l, m_rf_le, m_c, n_l, n_rf_le, n_c;
  logic [3:0]  m_ram, n_ram;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] model_opb(input stim_t s);
    case (s.soh)
      3'd1:    return 32'($signed(s.im[10:0]));
      3'd2:    return 32'($signed(s.im[13:0]));
      3'd3:    return {s.im, 11'b0};
      3'd4:    return 32'(s.im[4:0]);
      default: return s.fpb;
    endcase
  endfunction

  // Arithmetic in 64-bit integers: carry = unsigned result outside 32 bits
  // (or "no borrow"), overflow = signed result outside the 32-bit range.
  function automatic void model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic cin, output logic [31:0] res,
                                    output logic c, output logic v);
    longint ua, ub, sa, sb, sr, k;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b); k = cin;
    sr = 0; c = 1'b0; res = '0;
    case (op)
      4'd0: begin sr = sa + sb;     c = (ua + ub) >= 64'sd4294967296; end
      4'd1: begin sr = sa + sb + k; c = (ua + ub + k) >= 64'sd4294967296; end
      4'd2: begin sr = sa - sb;     c = ua >= ub; end
      4'd3: begin sr = sa - sb - (1 - k); c = ua >= ub + (1 - k); end
      4'd4: begin sr = sb - sa;     c = ub >= ua; end
      default: sr = 0;
    endcase
    v = (op <= 4'd4) && (sr > 64'sd2147483647 || sr < -64'sd2147483648);
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4: res = sr[31:0];
      4'd5: res = a | b;
      4'd6: res = a ^ b;
      4'd7: res = a & b;
      4'd8: res = a;
      4'd9: res = b;
      default: res = '0;
    endcase
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] rs, input stim_t s);
    logic       we[3];
    logic [4:0] id[3];
    we[0] = s.rf_le;    id[0] = s.idr;
    we[1] = m_rf_le;    id[1] = m_rd;
    we[2] = s.wb_rf_le; id[2] = s.wb_rd;
    if (rs == 5'd0) return 2'd0;
    for (int i = 0; i < 3; i++)
      if (we[i] && id[i] == rs) return 2'(i + 1);
    return 2'd0;
  endfunction

  task automatic apply(input stim_t s);
    exp_t        e;
    logic [31:0] res;
    logic        c, v, z, n, cr;
    ret_addr_i = s.ret_addr; ta_in_i = s.ta; fpa_i = s.fpa; fpb_i = s.fpb; im_i = s.im;
    idr_i = s.idr; ra_i = s.ra; rb_i = s.rb; sr_i = s.sr; wb_rd_i = s.wb_rd;
    wb_rf_le_i = s.wb_rf_le;
    ctrl_i = {s.psw, s.b, s.soh, s.alu, s.ram, s.l, s.rf_le, s.ub, s.neg, s.cond};
    model_alu(s.alu, s.fpa, model_opb(s), s.psw[0] ? m_c : 1'b0, res, c, v);
    z = (res == 0); n = res[31];
    case (s.cond)
      3'd1: cr = z;          3'd2: cr = n ^ v;
      3'd3: cr = (n ^ v) | z; 3'd4: cr = !c;
      3'd5: cr = !c | z;     3'd6: cr = v;
      3'd7: cr = res[0];     default: cr = 1'b0;
    endcase
    e.ex_j   = s.ub || (s.b && (cr ^ s.neg));
    e.target = s.ta;
    e.ex_out = s.ub ? 32'(s.ret_addr) : res;
    e.nop    = s.l && s.rf_le && s.idr != 0 &&
               ((s.sr[1] && s.ra == s.idr) || (s.sr[0] && s.rb == s.idr));
    e.le     = !e.nop;
    e.a_s    = model_fwd(s.ra, s);
    e.b_s    = model_fwd(s.rb, s);
    e.out_in = m_out; e.di = m_di; e.rd = m_rd; e.l = m_l; e.rf_le = m_rf_le; e.ram = m_ram;
    q.push_back(e);
    n_out = e.ex_out; n_di = s.fpb; n_rd = s.idr; n_l = s.l; n_rf_le = s.rf_le; n_ram = s.ram;
    n_c   = s.psw[1] ? c : m_c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_out = n_out; m_di = n_di; m_rd = n_rd; m_l = n_l; m_rf_le = n_rf_le; m_ram = n_ram;
    m_c = n_c;
  endtask

  task automatic clear_model();
    m_out = '0; m_di = '0; m_rd = '0; m_l = 1'b0; m_rf_le = 1'b0; m_ram = '0; m_c = 1'b0;
    n_out = '0; n_di = '0; n_rd = '0; n_l = 1'b0; n_rf_le = 1'b0; n_ram = '0; n_c = 1'b0;
  endtask

  task automatic check_regs_zero(input string tag);
    check({tag, "_ex_out_in"}, ex_out_in_o, 32'd0);
    check({tag, "_ex_di_in"}, ex_di_in_o, 32'd0);
    check({tag, "_ex_rd_in"}, 32'(ex_rd_in_o), 32'd0);
    check({tag, "_l_in"}, 32'(l_in_o), 32'd0);
    check({tag, "_rf_le_in"}, 32'(rf_le_in_o), 32'd0);
    check({tag, "_ram_ctrl_in"}, 32'(ram_ctrl_in_o), 32'd0);
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.ret_addr = 8'($urandom); s.ta = 8'($urandom);
    s.fpa = pick32(); s.fpb = pick32(); s.im = 21'($urandom);
    s.idr = 5'($urandom_range(0, 3)); s.ra = 5'($urandom_range(0, 3));
    s.rb = 5'($urandom_range(0, 3)); s.wb_rd = 5'($urandom_range(0, 3));
    s.psw = 2'($urandom); s.sr = 2'($urandom); s.soh = 3'($urandom);
    s.cond = 3'($urandom); s.alu = 4'($urandom_range(0, 10)); s.ram = 4'($urandom);
    s.b = 1'($urandom); s.l = 1'($urandom); s.rf_le = 1'($urandom);
    s.ub = ($urandom_range(0, 7) == 0); s.neg = 1'($urandom); s.wb_rf_le = 1'($urandom);
    return s;
  endfunction

  // Monitor: one expected record per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("ex_j", 32'(ex_j_o), 32'(e.ex_j));
      check("target_address", 32'(target_address_o), 32'(e.target));
      check("ex_out", ex_out_o, e.ex_out);
      check("nop", 32'(nop_o), 32'(e.nop));
      check("le", 32'(le_o), 32'(e.le));
      check("a_s", 32'(a_s_o), 32'(e.a_s));
      check("b_s", 32'(b_s_o), 32'(e.b_s));
      check("ex_out_in", ex_out_in_o, e.out_in);
      check("ex_di_in", ex_di_in_o, e.di);
      check("ex_rd_in", 32'(ex_rd_in_o), 32'(e.rd));
      check("l_in", 32'(l_in_o), 32'(e.l));
      check("rf_le_in", 32'(rf_le_in_o), 32'(e.rf_le));
      check("ram_ctrl_in", 32'(ram_ctrl_in_o), 32'(e.ram));
    end
  end

  initial begin
    stim_t s;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_regs_zero("reset");

    // ADD 5+7 into r3.
    s = '{default: '0};
    s.fpa = 32'd5; s.fpb = 32'd7; s.rf_le = 1'b1; s.idr = 5'd3;
    apply(s); #1 check("add_ex_out", ex_out_o, 32'd12);
    tick();
    check("add_ex_out_in", ex_out_in_o, 32'd12);
    check("add_ex_rd_in", 32'(ex_rd_in_o), 32'd3);
    check("add_rf_le_in", 32'(rf_le_in_o), 32'd1);

    // Forwarding for RA=3: EX, then MEM (previous EX), then WB only, then GR0.
    s = '{default: '0};
    s.ra = 5'd3; s.sr = 2'b10; s.idr = 5'd3; s.rf_le = 1'b1;
    apply(s); #1 check("fwd_ex", 32'(a_s_o), 32'd1);
    tick();
    s.rf_le = 1'b0; s.idr = 5'd0;
    apply(s); #1 check("fwd_mem", 32'(a_s_o), 32'd2);
    tick();
    s.wb_rd = 5'd3; s.wb_rf_le = 1'b1;
    apply(s); #1 check("fwd_wb", 32'(a_s_o), 32'd3);
    tick();
    s = '{default: '0};
    s.sr = 2'b10; s.rf_le = 1'b1; s.wb_rf_le = 1'b1;
    apply(s); #1 check("fwd_gr0", 32'(a_s_o), 32'd0);
    tick();

    // Load-use stall on RB, then the same with RB unused.
    s = '{default: '0};
    s.l = 1'b1; s.rf_le = 1'b1; s.idr = 5'd4; s.rb = 5'd4; s.sr = 2'b01;
    apply(s); #1 check("stall_nop", 32'(nop_o), 32'd1); check("stall_le", 32'(le_o), 32'd0);
    tick();
    s.sr = 2'b00;
    apply(s); #1 check("nostall_nop", 32'(nop_o), 32'd0); check("nostall_le", 32'(le_o), 32'd1);
    tick();

    // Branch on equal (9-9 sets Z), negated, and unconditional with link.
    s = '{default: '0};
    s.fpa = 32'd9; s.fpb = 32'd9; s.alu = 4'b0010; s.b = 1'b1; s.cond = 3'b001; s.ta = 8'h5A;
    apply(s); #1 check("beq_ex_j", 32'(ex_j_o), 32'd1);
    check("beq_target", 32'(target_address_o), 32'h5A);
    tick();
    s.neg = 1'b1;
    apply(s); #1 check("bne_ex_j", 32'(ex_j_o), 32'd0);
    tick();
    s.ub = 1'b1; s.ret_addr = 8'h2C;
    apply(s); #1 check("ub_ex_j", 32'(ex_j_o), 32'd1); check("ub_ex_out", ex_out_o, 32'h2C);
    tick();

    // Carry chain: 0xFFFFFFFF+1 latches C=1, then ADC 0+0 yields 1.
    s = '{default: '0};
    s.fpa = 32'hFFFF_FFFF; s.fpb = 32'd1; s.psw = 2'b10;
    apply(s); tick();
    s = '{default: '0};
    s.alu = 4'b0001; s.psw = 2'b01;
    apply(s); #1 check("adc_ex_out", ex_out_o, 32'd1);
    tick();

    // Load nonzero EX/MEM state and C=1, then reset mid-cycle with no clock edge.
    s = '{default: '0};
    s.fpa = 32'hFFFF_FFFF; s.fpb = 32'd2; s.psw = 2'b10; s.l = 1'b1; s.rf_le = 1'b1;
    s.ram = 4'hF; s.idr = 5'd7;
    apply(s); tick();
    #6 rst = 1'b1;
    #1 check_regs_zero("async_rst");
    clear_model();
    @(posedge clk);
    #1 rst = 1'b0;
    s = '{default: '0};
    s.alu = 4'b0001; s.psw = 2'b01;
    apply(s); #1 check("rst_psw_c", ex_out_o, 32'd0);
    tick();

    for (int i = 0; i < 500; i++) begin
      apply(rand_stim());
      tick();
    end

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
